// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, word width,
// PC step and default reset PC / halt opcode.
package fetch_unit_pkg;

    localparam int          INSTR_W            = 16;
    localparam logic [15:0] PC_INC             = 16'd2;
    localparam logic [15:0] RESET_PC_DEFAULT   = 16'h0000;
    localparam logic [3:0]  HLT_OPCODE_DEFAULT = 4'hF;

    typedef logic [INSTR_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_fsm.sv
// Fetch control FSM: state register plus next-state and IF/ID control decode.
// Redirect beats stall, which beats miss/hit/halt handling.
module fetch_unit_fsm
    import fetch_unit_pkg::*;
#(
    parameter logic [3:0] HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic         imem_ready,
    input  logic [3:0]   opcode,
    output fetch_state_e state,
    output logic         accept,
    output logic         advance_pc,
    output logic         load_redirect,
    output logic         ifid_wren,
    output logic         ifid_flush,
    output logic         imem_req,
    output logic         halted
);

    fetch_state_e next_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= next_state;
    end

    // NOTE: every output gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        advance_pc    = 1'b0;
        load_redirect = 1'b0;
        ifid_wren     = 1'b1;
        ifid_flush    = 1'b1;
        imem_req      = (state != HALTED);
        halted        = (state == HALTED);

        if (rst) begin
            if (redirect) begin
                load_redirect = 1'b1;
                next_state    = (state == FETCH && !imem_ready) ? DRAIN : FETCH;
            end else if (stall) begin
                ifid_wren  = 1'b0;
                ifid_flush = 1'b0;
                // An outstanding miss still completes while the pipe is held.
                if (state == DRAIN && imem_ready) next_state = FETCH;
            end else begin
                unique case (state)
                    FETCH: begin
                        if (imem_ready) begin
                            accept     = 1'b1;
                            ifid_flush = 1'b0;
                            if (opcode == HLT_OPCODE) next_state = HALTED;
                            else                      advance_pc = 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (imem_ready) next_state = FETCH;
                    end
                    HALTED: ;
                    default: next_state = FETCH;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC datapath, cache request and IF/ID producer.
// Optional FETCH_STATS_EN adds saturating fetch_cnt / bubble_cnt outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  word_t       redirect_pc,
    output logic        imem_req,
    output word_t       imem_addr,
    input  logic        imem_ready,
    input  word_t       imem_data,
    output word_t       pc_out,
    output word_t       instr_out,
    output logic        ifid_wren,
    output logic        ifid_flush,
    output logic        halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] bubble_cnt
`endif
);

    fetch_state_e state;
    word_t        pc;
    word_t        req_addr;
    logic         accept;
    logic         advance_pc;
    logic         load_redirect;

    fetch_unit_fsm #(
        .HLT_OPCODE (HLT_OPCODE)
    ) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .imem_ready    (imem_ready),
        .opcode        (imem_data[15:12]),
        .state         (state),
        .accept        (accept),
        .advance_pc    (advance_pc),
        .load_redirect (load_redirect),
        .ifid_wren     (ifid_wren),
        .ifid_flush    (ifid_flush),
        .imem_req      (imem_req),
        .halted        (halted)
    );

    // req_addr shadows pc while fetching, so it holds the missed address once
    // a redirect moves pc away and the FSM enters DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (load_redirect)   pc <= redirect_pc;
            else if (advance_pc) pc <= pc + PC_INC;
            if (state == FETCH)  req_addr <= pc;
        end
    end

    assign imem_addr = (state == DRAIN) ? req_addr : pc;
    assign pc_out    = pc + PC_INC;
    assign instr_out = accept ? imem_data : '0;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (accept && fetch_cnt != 16'hFFFF)      fetch_cnt  <= fetch_cnt + 16'd1;
            if (ifid_flush && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected IF/ID writes,
// a monitor pops and compares them whenever ifid_wren is high.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] pc_out;
    logic [15:0] instr_out;
    logic        ifid_wren;
    logic        ifid_flush;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt;
    logic [15:0] bubble_cnt;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        flush;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .ifid_wren   (ifid_wren),
        .ifid_flush  (ifid_flush),
        .halted      (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus; inputs change just after the rising edge.
    task automatic cycle(input logic rdy, input logic [15:0] data, input logic stl,
                         input logic rd, input logic [15:0] rpc,
                         input logic exp_req, input logic [15:0] exp_addr,
                         input logic exp_halted, input logic push,
                         input logic [15:0] exp_instr, input logic [15:0] exp_pc,
                         input logic exp_flush);
        @(posedge clk);
        #1;
        imem_ready  = rdy;
        imem_data   = data;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        if (push) sb_q.push_back('{exp_instr, exp_pc, exp_flush});
        #2;
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", {16'd0, imem_addr}, {16'd0, exp_addr});
        check("halted", {31'd0, halted}, {31'd0, exp_halted});
    endtask

    // Monitor: every IF/ID write must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && ifid_wren) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ifid_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("ifid_instr", {16'd0, instr_out}, {16'd0, e.instr});
                    check("ifid_pc",    {16'd0, pc_out},    {16'd0, e.pc});
                    check("ifid_flush", {31'd0, ifid_flush}, {31'd0, e.flush});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_ready  = 1'b0;
        imem_data   = 16'h0000;
        #3;
        check("rst_imem_req",   {31'd0, imem_req},   32'd1);
        check("rst_imem_addr",  {16'd0, imem_addr},  32'h0000);
        check("rst_ifid_flush", {31'd0, ifid_flush}, 32'd1);
        check("rst_ifid_wren",  {31'd0, ifid_wren},  32'd1);
        check("rst_halted",     {31'd0, halted},     32'd0);
        #9 rst = 1'b1;

        //      rdy data     stl rd rpc      req addr     hlt push instr    pc_out   fl
        // Back-to-back hits from reset.
        cycle(1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h1234, 16'h0002, 0);
        cycle(1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0002, 0, 1, 16'h1234, 16'h0004, 0);
        cycle(1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0004, 0, 1, 16'h1234, 16'h0006, 0);
        // Redirect to 0x0010, then three-cycle miss.
        cycle(1, 16'h1234, 0, 1, 16'h0010, 1, 16'h0006, 0, 1, 16'h0000, 16'h0008, 1);
        cycle(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010, 0, 1, 16'h0000, 16'h0012, 1);
        cycle(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010, 0, 1, 16'h0000, 16'h0012, 1);
        cycle(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010, 0, 1, 16'h0000, 16'h0012, 1);
        cycle(1, 16'h2222, 0, 0, 16'h0000, 1, 16'h0010, 0, 1, 16'h2222, 16'h0012, 0);
        // Redirect to 0x0020, two stall cycles, resume at 0x0020.
        cycle(1, 16'h1234, 0, 1, 16'h0020, 1, 16'h0012, 0, 1, 16'h0000, 16'h0014, 1);
        cycle(1, 16'h1234, 1, 0, 16'h0000, 1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h1234, 1, 0, 16'h0000, 1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h3333, 0, 0, 16'h0000, 1, 16'h0020, 0, 1, 16'h3333, 16'h0022, 0);
        // Redirect to 0x0040, miss, redirect to 0x0100 mid-miss, drain.
        cycle(1, 16'h1234, 0, 1, 16'h0040, 1, 16'h0022, 0, 1, 16'h0000, 16'h0024, 1);
        cycle(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040, 0, 1, 16'h0000, 16'h0042, 1);
        cycle(0, 16'h0000, 0, 1, 16'h0100, 1, 16'h0040, 0, 1, 16'h0000, 16'h0042, 1);
        cycle(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040, 0, 1, 16'h0000, 16'h0102, 1);
        cycle(1, 16'hABCD, 0, 0, 16'h0000, 1, 16'h0040, 0, 1, 16'h0000, 16'h0102, 1);
        cycle(1, 16'h5678, 0, 0, 16'h0000, 1, 16'h0100, 0, 1, 16'h5678, 16'h0102, 0);
        // Redirect to 0x0008, HLT delivered, halted, redirect out to 0x0030.
        cycle(1, 16'h1234, 0, 1, 16'h0008, 1, 16'h0102, 0, 1, 16'h0000, 16'h0104, 1);
        cycle(1, 16'hF000, 0, 0, 16'h0000, 1, 16'h0008, 0, 1, 16'hF000, 16'h000A, 0);
        cycle(1, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'h000A, 1);
        cycle(0, 16'h0000, 0, 1, 16'h0030, 0, 16'h0000, 1, 1, 16'h0000, 16'h000A, 1);
        cycle(1, 16'h4444, 0, 0, 16'h0000, 1, 16'h0030, 0, 1, 16'h4444, 16'h0032, 0);
        // Redirect with HLT on the bus: no halt; then PC wrap at 0xFFFE.
        cycle(1, 16'hF000, 0, 1, 16'hFFFE, 1, 16'h0032, 0, 1, 16'h0000, 16'h0034, 1);
        cycle(1, 16'h1234, 0, 0, 16'h0000, 1, 16'hFFFE, 0, 1, 16'h1234, 16'h0000, 0);
        cycle(1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h1234, 16'h0002, 0);
        // Redirect and stall together: redirect wins.
        cycle(1, 16'h1234, 1, 1, 16'h0050, 1, 16'h0002, 0, 1, 16'h0000, 16'h0004, 1);
        cycle(1, 16'h6666, 0, 0, 16'h0000, 1, 16'h0050, 0, 1, 16'h6666, 16'h0052, 0);
        // Park the pipe so no further IF/ID writes occur.
        cycle(1, 16'h1234, 1, 0, 16'h0000, 1, 16'h0052, 0, 0, 16'h0000, 16'h0000, 0);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 16-bit pipelined core: owns the program counter, issues requests to the instruction cache, and is the producer side of the IF/ID pipeline register. Drives the fetched instruction, its PC+2, and the IF/ID write-enable and flush controls. Absorbs multi-cycle cache misses, hazard stalls, taken-branch redirects from ID, and halts on HLT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, value of instr[15:12] that halts fetch.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold IF/ID and PC this cycle.
- redirect  in  1  taken branch resolved in ID.
- redirect_pc  in  16  branch target, valid with redirect.
- imem_req  out  1  cache request valid.
- imem_addr  out  16  cache request address.
- imem_ready  in  1  imem_data valid this cycle (same-cycle on hit).
- imem_data  in  16  instruction word.
- pc_out  out  16  PC+2 of delivered instruction, to IF/ID pc input.
- instr_out  out  16  delivered instruction, to IF/ID instr input.
- ifid_wren  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID flush (zeroes instr, i.e. inserts bubble).
- halted  out  1  high while in HALTED.

## Operation
- State: pc (16 b), req_addr (16 b), FSM {FETCH, DRAIN, HALTED}.
- imem_req = 1 in FETCH and DRAIN, 0 in HALTED. imem_addr = pc in FETCH, req_addr in DRAIN. req_addr tracks pc while in FETCH.
- accept = FETCH & imem_ready & !stall & !redirect.
- FETCH, accept: instr_out = imem_data, pc_out = pc+2, ifid_wren=1, ifid_flush=0; pc <= pc+2 (mod 2^16, 16'hFFFE -> 16'h0000). If imem_data[15:12]==HLT_OPCODE: pc unchanged, -> HALTED (HLT still delivered).
- FETCH, !imem_ready & !stall & !redirect (miss): ifid_wren=1, ifid_flush=1 (bubble); pc and address held stable.
- stall & !redirect: ifid_wren=0, ifid_flush=0; pc held; cache data, if any, discarded and refetched.
- redirect (priority over stall, miss, halt): ifid_flush=1, ifid_wren=1; pc <= redirect_pc. If in FETCH with !imem_ready (miss outstanding): -> DRAIN, req_addr frozen. Otherwise -> FETCH (including from HALTED and DRAIN).
- DRAIN: address held at req_addr; returned data discarded; ifid_flush=1, ifid_wren=1 each cycle; on imem_ready -> FETCH.
- HALTED: no requests; ifid_wren=1, ifid_flush=1; leaves only on redirect or reset.
- Outputs in non-accept cycles: instr_out=16'h0000, pc_out=pc+2.

## Timing
- Reset (async assert): pc=RESET_PC, state=FETCH, halted=0; first request on first edge after deassert. Combinational outputs during reset: imem_req=1, imem_addr=RESET_PC, ifid_flush=1, ifid_wren=1.
- Hit: instruction captured into IF/ID on same edge pc advances; one instruction per cycle, zero bubbles.
- Miss of N cycles: N bubbles, instruction delivered in cycle imem_ready rises.
- Redirect: one flushed slot; target request issued the following cycle (later if draining).
- Redirect and stall same cycle: redirect wins. Redirect and HLT returned same cycle: HLT discarded, no halt.
- Cache contract: imem_addr stable from imem_req assertion until imem_ready; guaranteed by DRAIN.

## Configuration
- FETCH_STATS_EN defined: adds outputs fetch_cnt (16 b, accepted instructions) and bubble_cnt (16 b, cycles with ifid_flush=1), both saturating at 16'hFFFF, cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: FSM state encoding, HLT_OPCODE, RESET_PC, instruction width (16) and PC increment (2).
- One sub-module natural: fetch_fsm (state register and next-state/control decode); PC datapath and counters in fetch_unit.

## Test plan
- Reset, cache always ready, imem_data=16'h1234 -> pc_out 0002,0004,0006 on successive cycles, ifid_wren=1, flush=0.
- Miss: imem_ready low 3 cycles at pc=0x0010 -> 3 flush cycles, imem_addr held 0x0010, then pc_out=0x0012.
- stall 2 cycles at pc=0x0020 -> ifid_wren=0 both, pc held, resume at 0x0020.
- redirect to 0x0100 during miss at 0x0040 -> DRAIN keeps addr 0x0040 until ready, data discarded, next request 0x0100.
- HLT (16'hF000) at pc=0x0008 -> delivered, halted=1, imem_req=0; redirect to 0x0030 -> fetch resumes at 0x0030.
- pc=0xFFFE hit -> pc_out=0x0000, next imem_addr=0x0000.
